// File: rtl/mmio_dma_pkg.sv
// Shared constants for the mmio_dma copy engine: register map, control/status
// bit positions and FSM state encodings.
package mmio_dma_pkg;

    localparam int ADDR_W = 32;
    localparam int LEN_W  = 16;

    localparam logic [2:0] REG_SRC    = 3'd0;
    localparam logic [2:0] REG_DST    = 3'd1;
    localparam logic [2:0] REG_LEN    = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_REMAIN = 3'd5;

    localparam int CTRL_START   = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_ABORT   = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4
    } dma_state_t;

endpackage

// File: rtl/mmio_dma_if.sv
// Master-side bus of the copy engine into the MMIO mapper's request/ready port.
interface mmio_dma_if;
    import mmio_dma_pkg::*;

    logic [ADDR_W-1:0] m_a;
    logic [31:0]       m_d;
    logic              m_we;
    logic              m_rd;
    logic [31:0]       m_spo;
    logic              m_ready;

    modport master (output m_a, m_d, m_we, m_rd, input m_spo, m_ready);
    modport slave  (input m_a, m_d, m_we, m_rd, output m_spo, m_ready);

endinterface

// File: rtl/mmio_dma_regs.sv
// CPU-facing register file of mmio_dma: decode, combinational readback,
// sticky DONE/ABORTED flags and the self-clearing START/ABORT strobes.
module mmio_dma_regs
    import mmio_dma_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        cfg_a,
    input  logic [31:0]       cfg_d,
    input  logic              cfg_we,
    output logic [31:0]       cfg_spo,
    input  logic              busy,
    input  logic [LEN_W-1:0]  remain,
    input  logic              done_set,
    input  logic              aborted_set,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic [LEN_W-1:0]  len,
    output logic              start_go,
    output logic              abort_go,
    output logic              irq
);

    logic [ADDR_W-3:0] src_q;
    logic [ADDR_W-3:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic              ie_q;
    logic              done_q;
    logic              aborted_q;

    logic wr_src, wr_dst, wr_len, wr_ctrl, wr_stat;

    assign wr_src   = cfg_we && (cfg_a == REG_SRC) && !busy;
    assign wr_dst   = cfg_we && (cfg_a == REG_DST) && !busy;
    assign wr_len   = cfg_we && (cfg_a == REG_LEN) && !busy;
    assign wr_ctrl  = cfg_we && (cfg_a == REG_CTRL);
    assign wr_stat  = cfg_we && (cfg_a == REG_STATUS);

    assign start_go = wr_ctrl && cfg_d[CTRL_START] && !busy;
    assign abort_go = wr_ctrl && cfg_d[CTRL_ABORT] && busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            ie_q      <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            if (wr_src) src_q <= cfg_d[ADDR_W-1:2];
            if (wr_dst) dst_q <= cfg_d[ADDR_W-1:2];
            if (wr_len) len_q <= cfg_d[LEN_W-1:0];
            if (wr_ctrl) ie_q <= cfg_d[CTRL_IE];
            // An internal set always beats a START clear or a software clear.
            if (done_set)
                done_q <= 1'b1;
            else if (start_go || (wr_stat && cfg_d[STAT_DONE]))
                done_q <= 1'b0;
            if (aborted_set)
                aborted_q <= 1'b1;
            else if (start_go || (wr_stat && cfg_d[STAT_ABORTED]))
                aborted_q <= 1'b0;
        end
    end

    always_comb begin
        cfg_spo = '0;
        case (cfg_a)
            REG_SRC:    cfg_spo = {src_q, 2'b00};
            REG_DST:    cfg_spo = {dst_q, 2'b00};
            REG_LEN:    cfg_spo = {{(32-LEN_W){1'b0}}, len_q};
            REG_CTRL:   cfg_spo = {30'd0, ie_q, 1'b0};
            REG_STATUS: cfg_spo = {29'd0, aborted_q, done_q, busy};
            REG_REMAIN: cfg_spo = {{(32-LEN_W){1'b0}}, remain};
            default:    cfg_spo = '0;
        endcase
    end

    assign src = {src_q, 2'b00};
    assign dst = {dst_q, 2'b00};
    assign len = len_q;
    assign irq = done_q && ie_q;

endmodule

// File: rtl/mmio_dma.sv
// Word-granular memory-to-memory copy engine: one read/write pulse pair per
// word on the mapper port, completing with sticky DONE and a level irq.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | no transfer; with pend_q set, started and waiting for m_ready
//   ST_RD_REQ  | one-cycle read pulse at the working source address
//   ST_RD_WAIT | wait for read completion, capture m_spo
//   ST_WR_REQ  | one-cycle write pulse of the captured word to destination
//   ST_WR_WAIT | wait for write completion, advance pointers and count
module mmio_dma
    import mmio_dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  cfg_a,
    input  logic [31:0] cfg_d,
    input  logic        cfg_we,
    output logic [31:0] cfg_spo,
    output logic        irq,
    mmio_dma_if.master  m
);

    dma_state_t state_q, state_d;
    logic       pend_q, pend_d;
    logic       abort_q;
    logic       first_q;
    logic       busy;

    logic [ADDR_W-1:0] src_w_q, dst_w_q, src_n, dst_n;
    logic [LEN_W-1:0]  cnt_q, cnt_n;
    logic [31:0]       data_q, data_n;

    logic [ADDR_W-1:0] m_a_q;
    logic [31:0]       m_d_q;
    logic              m_rd_q, m_we_q;

    logic [ADDR_W-1:0] reg_src, reg_dst;
    logic [LEN_W-1:0]  reg_len;
    logic              start_go, abort_go;
    logic              done_set, aborted_set;
    logic              load, capture, advance, accept;

    mmio_dma_regs u_regs (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_a       (cfg_a),
        .cfg_d       (cfg_d),
        .cfg_we      (cfg_we),
        .cfg_spo     (cfg_spo),
        .busy        (busy),
        .remain      (cnt_q),
        .done_set    (done_set),
        .aborted_set (aborted_set),
        .src         (reg_src),
        .dst         (reg_dst),
        .len         (reg_len),
        .start_go    (start_go),
        .abort_go    (abort_go),
        .irq         (irq)
    );

    assign busy = (state_q != ST_IDLE) || pend_q;

    // The mapper may keep ready high for the cycle after a pulse; ignore it.
    assign accept = m.m_ready && !first_q;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        done_set    = 1'b0;
        aborted_set = 1'b0;
        load        = 1'b0;
        capture     = 1'b0;
        advance     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_go) begin
                    if (reg_len == '0) begin
                        done_set = 1'b1;
                    end else begin
                        load = 1'b1;
                        if (m.m_ready) state_d = ST_RD_REQ;
                        else           pend_d  = 1'b1;
                    end
                end else if (pend_q && m.m_ready) begin
                    pend_d  = 1'b0;
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (accept) begin
                    capture = 1'b1;
                    if (abort_q) begin
                        state_d     = ST_IDLE;
                        done_set    = 1'b1;
                        aborted_set = 1'b1;
                    end else begin
                        state_d = ST_WR_REQ;
                    end
                end
            end
            ST_WR_REQ: state_d = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (accept) begin
                    advance = 1'b1;
                    if ((cnt_q == LEN_W'(1)) || abort_q) begin
                        state_d     = ST_IDLE;
                        done_set    = 1'b1;
                        aborted_set = abort_q;
                    end else begin
                        state_d = ST_RD_REQ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        src_n  = load ? reg_src : (advance ? src_w_q + ADDR_W'(4) : src_w_q);
        dst_n  = load ? reg_dst : (advance ? dst_w_q + ADDR_W'(4) : dst_w_q);
        cnt_n  = load ? reg_len : (advance ? cnt_q - LEN_W'(1) : cnt_q);
        data_n = capture ? m.m_spo : data_q;
    end

    // Bus strobes are registered from next-state so they never follow m_ready
    // combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_q <= 1'b0;
            first_q <= 1'b0;
            src_w_q <= '0;
            dst_w_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            m_rd_q  <= 1'b0;
            m_we_q  <= 1'b0;
            m_a_q   <= '0;
            m_d_q   <= '0;
        end else begin
            abort_q <= done_set ? 1'b0 : (abort_q || abort_go);
            first_q <= (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
            src_w_q <= src_n;
            dst_w_q <= dst_n;
            cnt_q   <= cnt_n;
            data_q  <= data_n;
            m_rd_q  <= (state_d == ST_RD_REQ);
            m_we_q  <= (state_d == ST_WR_REQ);
            if (state_d == ST_RD_REQ)
                m_a_q <= src_n;
            else if (state_d == ST_WR_REQ)
                m_a_q <= dst_n;
            if (state_d == ST_WR_REQ)
                m_d_q <= data_n;
        end
    end

    assign m.m_a  = m_a_q;
    assign m.m_d  = m_d_q;
    assign m.m_rd = m_rd_q;
    assign m.m_we = m_we_q;

endmodule

// File: tb/tb_mmio_dma.sv
// Scoreboard bench for mmio_dma: directed transfers push expected bus pulses,
// a negedge monitor pops and compares each read/write pulse the engine issues.
`timescale 1ns/1ps
module tb_mmio_dma;
    import mmio_dma_pkg::*;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [2:0]  cfg_a  = '0;
    logic [31:0] cfg_d  = '0;
    logic        cfg_we = 1'b0;
    logic [31:0] cfg_spo;
    logic        irq;

    mmio_dma_if bus();

    mmio_dma dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_a   (cfg_a),
        .cfg_d   (cfg_d),
        .cfg_we  (cfg_we),
        .cfg_spo (cfg_spo),
        .irq     (irq),
        .m       (bus)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int bad    = 0;
    int npulse = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
    } txn_t;
    txn_t exp_q[$];
    txn_t mon_e;

    // Mapper model: ready drops for 3 cycles after each accepted pulse.
    int          bsy     = 0;
    logic        stall   = 1'b0;
    logic [31:0] rdata   = '0;
    logic [31:0] spo_xor = '0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    assign bus.m_ready = (bsy == 0) && !stall;
    assign bus.m_spo   = rdata ^ spo_xor;

    always @(posedge clk) begin
        if (bus.m_rd || bus.m_we) begin
            bsy <= 3;
            if (bus.m_rd) rdata <= mem_f(bus.m_a);
        end else if (bsy != 0) begin
            bsy <= bsy - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.m_rd || bus.m_we)) begin
            npulse++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL bus_unexpected: got we=%0d a=%h d=%h expected no pulse",
                         bus.m_we, bus.m_a, bus.m_d);
            end else begin
                mon_e = exp_q.pop_front();
                check("bus_kind", {31'd0, bus.m_we}, {31'd0, mon_e.we});
                check("bus_addr", bus.m_a, mon_e.a);
                if (mon_e.we) check("bus_wdata", bus.m_d, mon_e.d);
            end
        end
    end

    task automatic push_rd(input logic [31:0] a);
        exp_q.push_back('{we: 1'b0, a: a, d: 32'd0});
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{we: 1'b1, a: a, d: d});
    endtask

    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            push_rd(s + 32'(4 * i));
            push_wr(d + 32'(4 * i), mem_f(s + 32'(4 * i)));
        end
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
        cfg_a = a;
        #1;
        d = cfg_spo;
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the write.
    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        cfg_a  = a;
        cfg_d  = d;
        cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        logic [31:0] s;
        n = 0;
        rd_reg(REG_STATUS, s);
        while (s[STAT_BUSY] && n < 500) begin
            @(negedge clk);
            n++;
            rd_reg(REG_STATUS, s);
        end
        if (s[STAT_BUSY]) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
        end
    endtask

    logic [31:0] r;
    int          n;
    int          np0;
    localparam logic [31:0] K = 32'h0BAD_F00D;

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_m_rd", {31'd0, bus.m_rd}, 32'd0);
        check("rst_m_we", {31'd0, bus.m_we}, 32'd0);
        check("rst_m_a",  bus.m_a, 32'd0);
        check("rst_m_d",  bus.m_d, 32'd0);
        check("rst_irq",  {31'd0, irq}, 32'd0);
        rd_reg(REG_STATUS, r); check("rst_status", r, 32'd0);
        rd_reg(REG_SRC, r);    check("rst_src", r, 32'd0);
        rd_reg(REG_REMAIN, r); check("rst_remain", r, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Four-word copy with IE
        wr_reg(REG_SRC, 32'h1000_0000);
        wr_reg(REG_DST, 32'h1000_0100);
        wr_reg(REG_LEN, 32'd4);
        push_copy(32'h1000_0000, 32'h1000_0100, 4);
        wr_reg(REG_CTRL, 32'h3);
        check("t1_first_rd", {31'd0, bus.m_rd}, 32'd1);
        rd_reg(REG_STATUS, r); check("t1_busy", r, 32'h1);
        wait_idle(n);
        check("t1_cycles", 32'(n), 32'd40);
        rd_reg(REG_STATUS, r); check("t1_status", r, 32'h2);
        check("t1_irq", {31'd0, irq}, 32'd1);
        rd_reg(REG_REMAIN, r); check("t1_remain", r, 32'd0);
        rd_reg(REG_CTRL, r);   check("t1_ctrl", r, 32'h2);
        check("t1_queue", 32'(exp_q.size()), 32'd0);

        // DONE write-1-clear, then LEN=0 start
        wr_reg(REG_STATUS, 32'h2);
        rd_reg(REG_STATUS, r); check("w1c_status", r, 32'd0);
        check("w1c_irq", {31'd0, irq}, 32'd0);
        wr_reg(REG_LEN, 32'd0);
        np0 = npulse;
        wr_reg(REG_CTRL, 32'h1);
        rd_reg(REG_STATUS, r); check("len0_status", r, 32'h2);
        repeat (5) @(negedge clk);
        check("len0_pulses", 32'(npulse - np0), 32'd0);

        // Read stalled 20 cycles; data captured at the first ready cycle
        wr_reg(REG_SRC, 32'h0000_2000);
        wr_reg(REG_DST, 32'h0000_3000);
        wr_reg(REG_LEN, 32'd1);
        push_rd(32'h0000_2000);
        push_wr(32'h0000_3000, mem_f(32'h0000_2000) ^ K);
        np0 = npulse;
        wr_reg(REG_CTRL, 32'h1);
        stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            spo_xor = $urandom;
        end
        check("stall_pulses", 32'(npulse - np0), 32'd1);
        spo_xor = K;
        stall   = 1'b0;
        wait_idle(n);
        spo_xor = '0;
        rd_reg(REG_STATUS, r); check("stall_status", r, 32'h2);
        check("stall_queue", 32'(exp_q.size()), 32'd0);

        // Abort during the third RD_WAIT of a 100-word copy
        wr_reg(REG_SRC, 32'h0000_4000);
        wr_reg(REG_DST, 32'h0000_5000);
        wr_reg(REG_LEN, 32'd100);
        push_copy(32'h0000_4000, 32'h0000_5000, 2);
        push_rd(32'h0000_4008);
        wr_reg(REG_CTRL, 32'h1);
        repeat (22) @(negedge clk);
        wr_reg(REG_CTRL, 32'h4);
        wait_idle(n);
        rd_reg(REG_STATUS, r); check("abort_status", r, 32'h6);
        rd_reg(REG_REMAIN, r); check("abort_remain", r, 32'd98);
        check("abort_irq", {31'd0, irq}, 32'd0);
        repeat (15) @(negedge clk);
        check("abort_queue", 32'(exp_q.size()), 32'd0);

        // Source address wraps through zero
        wr_reg(REG_SRC, 32'hFFFF_FFF8);
        wr_reg(REG_DST, 32'h0000_6000);
        wr_reg(REG_LEN, 32'd3);
        push_rd(32'hFFFF_FFF8); push_wr(32'h0000_6000, mem_f(32'hFFFF_FFF8));
        push_rd(32'hFFFF_FFFC); push_wr(32'h0000_6004, mem_f(32'hFFFF_FFFC));
        push_rd(32'h0000_0000); push_wr(32'h0000_6008, mem_f(32'h0000_0000));
        wr_reg(REG_CTRL, 32'h1);
        wait_idle(n);
        rd_reg(REG_STATUS, r); check("wrap_status", r, 32'h2);
        check("wrap_queue", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while in WR_WAIT, then a normal copy
        wr_reg(REG_SRC, 32'h0000_7000);
        wr_reg(REG_DST, 32'h0000_8000);
        wr_reg(REG_LEN, 32'd2);
        push_rd(32'h0000_7000);
        push_wr(32'h0000_8000, mem_f(32'h0000_7000));
        wr_reg(REG_CTRL, 32'h3);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_m_rd", {31'd0, bus.m_rd}, 32'd0);
        check("arst_m_we", {31'd0, bus.m_we}, 32'd0);
        check("arst_m_a",  bus.m_a, 32'd0);
        check("arst_m_d",  bus.m_d, 32'd0);
        check("arst_irq",  {31'd0, irq}, 32'd0);
        rd_reg(REG_STATUS, r); check("arst_status", r, 32'd0);
        rd_reg(REG_REMAIN, r); check("arst_remain", r, 32'd0);
        check("arst_queue", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        wr_reg(REG_SRC, 32'h0000_9003);
        rd_reg(REG_SRC, r); check("arst_src_rb", r, 32'h0000_9000);
        wr_reg(REG_DST, 32'h0000_A000);
        wr_reg(REG_LEN, 32'd2);
        push_copy(32'h0000_9000, 32'h0000_A000, 2);
        wr_reg(REG_CTRL, 32'h1);
        wait_idle(n);
        check("post_cycles", 32'(n), 32'd20);
        rd_reg(REG_STATUS, r); check("post_status", r, 32'h2);
        check("post_queue", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1);
    end

endmodule
